pipelined_main_memory: RTL

- Main-memory responder on the far side of the cache miss/fill interface; answers the word requests the cache fill FSM issues on a miss.
- Word-addressed, single-ported, 16-bit data, with a fixed read latency.
- Fully pipelined: accepts one request per cycle, so an 8-word line fill issues back-to-back.
- Returns each read word with a valid strobe and the matching address, so the requester can steer the word into its data array.

---
 rtl/pipelined_main_memory.sv | 76 +++++++
 1 files changed

// File: rtl/pipelined_main_memory.sv
// Main-memory responder for cache line fills: word-addressed, single-ported,
// fully pipelined reads with a fixed latency and address-tagged responses.
module pipelined_main_memory #(
    parameter int ADDR_WIDTH = 16,
    parameter int LATENCY    = 4,
    parameter int CNT_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  wr,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [15:0]           data_in,
    output logic [15:0]           data_out,
    output logic                  data_valid,
    output logic [ADDR_WIDTH-1:0] resp_addr,
    output logic [CNT_WIDTH-1:0]  in_flight
);

    logic [15:0]           mem [2**ADDR_WIDTH];
    logic [LATENCY-1:0]    vld;
    logic [ADDR_WIDTH-1:0] st_addr [LATENCY];
    logic [15:0]           st_data [LATENCY];
    logic                  rd;

    assign rd = enable && !wr;

    // Array is deliberately not reset; contents are undefined at power-up.
    always_ff @(posedge clk) begin
        if (enable && wr) begin
            mem[addr] <= data_in;
        end
    end

    // Stage 0 snapshots the array at acceptance, so a later write cannot
    // disturb a word already travelling down the pipe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                st_addr[i] <= '0;
                st_data[i] <= '0;
            end
        end else begin
            vld[0]     <= rd;
            st_addr[0] <= addr;
            st_data[0] <= mem[addr];
            for (int i = 1; i < LATENCY; i++) begin
                vld[i]     <= vld[i-1];
                st_addr[i] <= st_addr[i-1];
                st_data[i] <= st_data[i-1];
            end
        end
    end

    assign data_valid = vld[LATENCY-1];
    assign data_out   = data_valid ? st_data[LATENCY-1] : '0;
    assign resp_addr  = data_valid ? st_addr[LATENCY-1] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_flight <= '0;
        end else begin
            case ({rd, data_valid})
                2'b10:   in_flight <= in_flight + CNT_WIDTH'(1);
                2'b01:   in_flight <= in_flight - CNT_WIDTH'(1);
                default: in_flight <= in_flight;
            endcase
        end
    end

    a_in_flight_bound: assert property (
        @(posedge clk) disable iff (rst) in_flight <= CNT_WIDTH'(LATENCY)
    ) else $error("in_flight exceeded LATENCY");

endmodule
